// File: rtl/ram_sp_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port, write-first block RAM
// (1-cycle registered read) between requesters A and B; one access per 3 cycles.
module ram_sp_arbiter #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic                    owner_b, owner_b_nxt;
  logic                    last_b, last_b_nxt;
  logic                    pick_b;
  logic [ADDR_WIDTH-1:0]   ram_addr_nxt;
  logic                    ram_we_nxt;
  logic [DATA_WIDTH-1:0]   ram_din_nxt;
  logic                    a_rvalid_nxt, b_rvalid_nxt;
  logic [DATA_WIDTH-1:0]   a_rdata_nxt, b_rdata_nxt;
  logic                    busy_nxt;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner_b  <= 1'b0;
      last_b   <= 1'b1;
      ram_addr <= '0;
      ram_we   <= 1'b0;
      ram_din  <= '0;
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner_b  <= owner_b_nxt;
      last_b   <= last_b_nxt;
      ram_addr <= ram_addr_nxt;
      ram_we   <= ram_we_nxt;
      ram_din  <= ram_din_nxt;
      a_rvalid <= a_rvalid_nxt;
      a_rdata  <= a_rdata_nxt;
      b_rvalid <= b_rvalid_nxt;
      b_rdata  <= b_rdata_nxt;
      busy     <= busy_nxt;
    end
  end

  // B wins only when alone or when A owned the previous access
  assign pick_b = b_req && (!a_req || !last_b);

  // Next-state, grant and datapath selection
  always_comb begin
    state_nxt    = state;
    a_gnt        = 1'b0;
    b_gnt        = 1'b0;
    owner_b_nxt  = owner_b;
    last_b_nxt   = last_b;
    ram_addr_nxt = ram_addr;
    ram_we_nxt   = 1'b0;
    ram_din_nxt  = ram_din;
    a_rvalid_nxt = 1'b0;
    b_rvalid_nxt = 1'b0;
    a_rdata_nxt  = a_rdata;
    b_rdata_nxt  = b_rdata;

    unique case (state)
      IDLE: begin
        if (!rst && (a_req || b_req)) begin
          a_gnt        = !pick_b;
          b_gnt        = pick_b;
          owner_b_nxt  = pick_b;
          last_b_nxt   = pick_b;
          ram_addr_nxt = pick_b ? b_addr : a_addr;
          ram_we_nxt   = pick_b ? b_we : a_we;
          ram_din_nxt  = pick_b ? b_din : a_din;
          state_nxt    = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (owner_b) begin
          b_rdata_nxt  = ram_dout;
          b_rvalid_nxt = 1'b1;
        end else begin
          a_rdata_nxt  = ram_dout;
          a_rvalid_nxt = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Bench for ram_sp_arbiter: write-first RAM model, transaction-level scoreboard
// checked every cycle, directed vector table, corner sequences and random traffic.
module tb_ram_sp_arbiter;

  localparam int unsigned DW    = 128;
  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          a_req  = 1'b0;
  logic          a_we   = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_din  = '0;
  logic          b_req  = 1'b0;
  logic          b_we   = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_din  = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, busy;
  logic [DW-1:0] a_rdata, b_rdata, ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic [AW-1:0] ram_addr;

  int n_checks = 0;
  int n_pass   = 0;

  ram_sp_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {4{20'hC0DE0, a}};
  endfunction

  // Write-first RAM; never-written words return init_word(addr)
  logic [DW-1:0] ram_mem [DEPTH];
  bit            ram_wr  [DEPTH];
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_din;
      ram_wr[ram_addr]  <= 1'b1;
      ram_dout          <= ram_din;
    end else begin
      ram_dout <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_word(ram_addr);
    end
  end

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
  endtask

  task automatic checkw(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Scoreboard: at most one access in flight; it is granted at step p_t and
  // answers at p_t+3, with the RAM write slot at p_t+1.
  int            cyc;
  bit            p_valid, p_b, p_we;
  int            p_t;
  logic [DW-1:0] p_data;
  bit            m_last_b;
  logic [DW-1:0] m_rd_a, m_rd_b, m_din;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_wr  [DEPTH];

  task automatic model_reset();
    p_valid  = 1'b0;
    m_last_b = 1'b1;
    m_rd_a   = '0;
    m_rd_b   = '0;
    m_addr   = '0;
    m_din    = '0;
  endtask

  task automatic mon_step();
    bit            rv_a, rv_b, e_busy, e_we, g_a, g_b;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    rv_a   = p_valid && (cyc == p_t + 3) && !p_b;
    rv_b   = p_valid && (cyc == p_t + 3) && p_b;
    if (rv_a) m_rd_a = p_data;
    if (rv_b) m_rd_b = p_data;
    e_busy = p_valid && (cyc > p_t) && (cyc < p_t + 3);
    e_we   = p_valid && p_we && (cyc == p_t + 1);
    g_a = 1'b0;
    g_b = 1'b0;
    if (!rst && !e_busy && (a_req || b_req)) begin
      if (a_req && b_req) begin
        g_a = m_last_b;
        g_b = !m_last_b;
      end else begin
        g_a = a_req;
        g_b = b_req;
      end
    end
    check1("mon_a_gnt", a_gnt, g_a);
    check1("mon_b_gnt", b_gnt, g_b);
    check1("mon_busy", busy, e_busy);
    check1("mon_a_rvalid", a_rvalid, rv_a);
    check1("mon_b_rvalid", b_rvalid, rv_b);
    checkw("mon_a_rdata", a_rdata, m_rd_a);
    checkw("mon_b_rdata", b_rdata, m_rd_b);
    check1("mon_ram_we", ram_we, e_we);
    checkw("mon_ram_addr", DW'(ram_addr), DW'(m_addr));
    checkw("mon_ram_din", ram_din, m_din);
    if (rst) begin
      model_reset();
    end else if (g_a || g_b) begin
      ga      = g_b ? b_addr : a_addr;
      gd      = g_b ? b_din : a_din;
      p_valid = 1'b1;
      p_b     = g_b;
      p_we    = g_b ? b_we : a_we;
      p_t     = cyc;
      p_data  = p_we ? gd : (ref_wr[ga] ? ref_mem[ga] : init_word(ga));
      if (p_we) begin
        ref_mem[ga] = gd;
        ref_wr[ga]  = 1'b1;
      end
      m_last_b = g_b;
      m_addr   = ga;
      m_din    = gd;
    end
    cyc++;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(negedge clk);
      #1;
      mon_step();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_gnt(input bit pb, input int limit, output int waited);
    bit ok;
    ok     = 1'b0;
    waited = 0;
    #2;
    for (int i = 0; i < limit; i++) begin
      if ((pb ? b_gnt : a_gnt) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #2;
      waited++;
    end
    check1("gnt_within_bound", ok, 1'b1);
  endtask

  typedef struct {
    bit            port_b;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_data;
  } vec_t;

  // Single access from idle: grant same cycle, response exactly 3 cycles later
  task automatic run_vec(input vec_t v);
    int waited;
    @(negedge clk);
    if (v.port_b) begin
      b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_din = v.din;
    end else begin
      a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_din = v.din;
    end
    wait_gnt(v.port_b, 8, waited);
    check_int("vec_gnt_latency", waited, 0);
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
    #2;
    check1("vec_rvalid_t1", v.port_b ? b_rvalid : a_rvalid, 1'b0);
    @(negedge clk);
    #2;
    check1("vec_rvalid_t2", v.port_b ? b_rvalid : a_rvalid, 1'b0);
    @(negedge clk);
    #2;
    check1("vec_rvalid_t3", v.port_b ? b_rvalid : a_rvalid, 1'b1);
    checkw("vec_rdata", v.port_b ? b_rdata : a_rdata, v.exp_data);
  endtask

  vec_t vecs[9];

  initial begin
    int   n_gnt, last_s, waited;
    bit   a_got, b_got;
    vec_t v;
    logic [DW-1:0] pat;

    vecs[0] = '{1'b0, 1'b0, 12'h005, '0, init_word(12'h005)};
    vecs[1] = '{1'b0, 1'b1, 12'h010, 128'hDEAD, 128'hDEAD};
    vecs[2] = '{1'b1, 1'b0, 12'h010, '0, 128'hDEAD};
    vecs[3] = '{1'b1, 1'b1, 12'hFFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
    vecs[4] = '{1'b0, 1'b0, 12'hFFF, '0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
    vecs[5] = '{1'b0, 1'b0, 12'h000, '0, init_word(12'h000)};
    vecs[6] = '{1'b1, 1'b1, 12'h000, '1, '1};
    vecs[7] = '{1'b0, 1'b0, 12'h000, '0, '1};
    vecs[8] = '{1'b1, 1'b0, 12'h7FF, '0, init_word(12'h7FF)};

    // Grants suppressed while reset is held, even with both requesting
    @(negedge clk);
    a_req = 1'b1;
    b_req = 1'b1;
    #2;
    check1("rst_a_gnt", a_gnt, 1'b0);
    check1("rst_b_gnt", b_gnt, 1'b0);
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check1("rst_busy", busy, 1'b0);
    check1("rst_ram_we", ram_we, 1'b0);
    check1("rst_a_rvalid", a_rvalid, 1'b0);
    check1("rst_b_rvalid", b_rvalid, 1'b0);
    checkw("rst_a_rdata", a_rdata, '0);
    checkw("rst_b_rdata", b_rdata, '0);
    checkw("rst_ram_addr", DW'(ram_addr), '0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Continuous dual requests from reset: strict alternation, 3-cycle spacing
    @(negedge clk);
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h100; a_din = '0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h200; b_din = '0;
    @(negedge clk);
    rst    = 1'b0;
    n_gnt  = 0;
    last_s = 0;
    for (int s = 0; s < 80; s++) begin
      #2;
      if (a_gnt || b_gnt) begin
        check1("fair_owner_is_b", b_gnt, n_gnt[0]);
        if (n_gnt == 0) check_int("fair_first_step", s, 0);
        else            check_int("fair_spacing", s - last_s, 3);
        last_s = s;
        n_gnt++;
      end
      if (n_gnt == 20) break;
      @(negedge clk);
    end
    check_int("fair_grant_count", n_gnt, 20);
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (4) @(negedge clk);

    // Same-address A write / B read with last owner B: A first, B sees A's data
    v = '{1'b1, 1'b0, 12'h7FF, '0, init_word(12'h7FF)};
    run_vec(v);
    pat = 128'hFACE_0000_1111_2222_3333_4444_5555_6666;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 12'h020; a_din = pat;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h020; b_din = '0;
    #2;
    check1("t4_a_gnt_first", a_gnt, 1'b1);
    check1("t4_b_waits", b_gnt, 1'b0);
    @(negedge clk);
    a_req = 1'b0;
    #2;
    check1("t4_b_no_gnt_access", b_gnt, 1'b0);
    @(negedge clk);
    #2;
    check1("t4_b_no_gnt_resp", b_gnt, 1'b0);
    @(negedge clk);
    #2;
    check1("t4_a_rvalid", a_rvalid, 1'b1);
    checkw("t4_a_rdata", a_rdata, pat);
    check1("t4_b_gnt_t3", b_gnt, 1'b1);
    @(negedge clk);
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check1("t4_b_rvalid", b_rvalid, 1'b1);
    checkw("t4_b_rdata", b_rdata, pat);

    // B request raised during ACCESS waits for IDLE
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h040;
    #2;
    check1("t6_a_gnt", a_gnt, 1'b1);
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h010;
    #2;
    check1("t6_b_no_gnt_access", b_gnt, 1'b0);
    @(negedge clk);
    #2;
    check1("t6_b_no_gnt_resp", b_gnt, 1'b0);
    @(negedge clk);
    #2;
    check1("t6_b_gnt_idle", b_gnt, 1'b1);
    @(negedge clk);
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checkw("t6_b_rdata", b_rdata, 128'hDEAD);

    // Reset during RESP of an A read: response dropped, last owner back to B
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h005;
    #2;
    check1("t5_a_gnt", a_gnt, 1'b1);
    @(negedge clk);
    a_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    check1("t5_busy_in_resp", busy, 1'b1);
    @(negedge clk);
    rst   = 1'b0;
    a_req = 1'b1; a_addr = 12'h006;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h007;
    #2;
    check1("t5_no_a_rvalid", a_rvalid, 1'b0);
    check1("t5_busy_clear", busy, 1'b0);
    check1("t5_ram_we_clear", ram_we, 1'b0);
    check1("t5_a_wins_after_rst", a_gnt, 1'b1);
    @(negedge clk);
    a_req = 1'b0;
    wait_gnt(1'b1, 8, waited);
    check_int("t5_b_gnt_wait", waited, 2);
    @(negedge clk);
    b_req = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during ACCESS of a write: ram_we dropped next cycle, write lands
    pat = 128'h5A5A_0000_0000_0000_0000_0000_0000_A5A5;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 12'h030; a_din = pat;
    #2;
    check1("t5b_a_gnt", a_gnt, 1'b1);
    @(negedge clk);
    a_req = 1'b0;
    rst   = 1'b1;
    #2;
    check1("t5b_ram_we_access", ram_we, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check1("t5b_ram_we_cleared", ram_we, 1'b0);
    check1("t5b_busy_cleared", busy, 1'b0);
    v = '{1'b1, 1'b0, 12'h030, '0, pat};
    run_vec(v);

    // Random traffic with occasional resets, checked by the scoreboard
    a_got = 1'b0;
    b_got = 1'b0;
    for (int s = 0; s < 1500; s++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      if (a_got) a_req = 1'b0;
      if (b_got) b_req = 1'b0;
      if (!a_req && $urandom_range(0, 2) != 0) begin
        a_req  = 1'b1;
        a_we   = 1'($urandom_range(0, 1));
        a_addr = ($urandom_range(0, 3) == 0) ? 12'hFFF : AW'($urandom_range(0, 15));
        a_din  = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (!b_req && $urandom_range(0, 2) != 0) begin
        b_req  = 1'b1;
        b_we   = 1'($urandom_range(0, 1));
        b_addr = ($urandom_range(0, 3) == 0) ? 12'hFFF : AW'($urandom_range(0, 15));
        b_din  = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      #2;
      a_got = a_gnt;
      b_got = b_gnt;
    end
    @(negedge clk);
    rst   = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (6) @(negedge clk);
    #3;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
